// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcodes, ALU op classes, mux selects and the packed control word.
package mips_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned CTRL_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

  localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_BOFF = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_OUT  = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
  } ctrl_t;

  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Control-word decoder: maps the current state (and effective memory ready)
// onto the datapath strobes and mux selects.
module mcu_output_decode
  import mips_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_mem_ready,
  output logic [CTRL_W-1:0]  o_ctrl
);

  state_t w_state;
  ctrl_t  w_ctrl;

  assign w_state = state_t'(i_state);
  assign o_ctrl  = w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (w_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BOFF;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: w_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_REG;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_source     = PCSRC_OUT;
        w_ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_write  = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state sequencing, retired-instruction counter
// and sticky illegal-opcode flag; control outputs come from mcu_output_decode.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic [SEL_W-1:0]    pc_source,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_op,
  output logic [COUNT_W-1:0]  instr_count
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_ready;
  logic                 w_retire;
  logic [COUNT_W-1:0]   r_instr_count;
  logic                 r_illegal_op;
  logic [CTRL_W-1:0]    w_ctrl_bits;
  ctrl_t                w_ctrl;

  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Next-state and retire decision
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        w_next   = w_ready ? S_FETCH : S_MEMWR;
        w_retire = w_ready;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
      r_illegal_op  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
      if ((r_state == S_DECODE) && !is_known_op(opcode)) r_illegal_op <= 1'b1;
    end
  end

  mcu_output_decode u_decode (
    .i_state     (4'(r_state)),
    .i_mem_ready (w_ready),
    .o_ctrl      (w_ctrl_bits)
  );

  assign w_ctrl        = ctrl_t'(w_ctrl_bits);
  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign state         = 4'(r_state);
  assign illegal_op    = r_illegal_op;
  assign instr_count   = r_instr_count;

endmodule
